scalar_wb_arbiter: RTL and testbench

SCALAR_WB_ARBITER -- requirements
Module: scalar_wb_arbiter

---
 rtl/scalar_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_scalar_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_wb_arbiter.sv
// scalar_wb_arbiter
// Arbitrates two writeback requesters (ALU result, memory load) onto the single
// write port of the scalar register file, and keeps a per-register scoreboard
// so that decode can detect RAW hazards and issue can stall on WAW.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   alu_valid/alu_wa/alu_wd       ALU writeback request; alu_ready = granted
//   mem_valid/mem_wa/mem_wd       load writeback request; mem_ready = granted
//   iss_valid/iss_rd, iss_ready   reserve a destination register at issue
//   chk_ra1/chk_ra2, hazard       source registers of decode, pending-write flag
//   we3/wa3/wd3                   registered register-file write port
//   busy                          scoreboard, one bit per register
//   err_unexp                     sticky: a write landed on a non-busy register
//
// Last-grant pointer
//   state    | meaning
//   LAST_ALU | ALU won the most recent grant, MEM wins the next tie
//   LAST_MEM | MEM won the most recent grant (reset), ALU wins the next tie

module scalar_wb_arbiter #(
    parameter int DATA_WIDTH   = 19,
    parameter int REGNUM       = 16,
    parameter int ADDRESSWIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid,
    input  logic [ADDRESSWIDTH-1:0] alu_wa,
    input  logic [DATA_WIDTH-1:0]   alu_wd,
    output logic                    alu_ready,
    input  logic                    mem_valid,
    input  logic [ADDRESSWIDTH-1:0] mem_wa,
    input  logic [DATA_WIDTH-1:0]   mem_wd,
    output logic                    mem_ready,
    input  logic                    iss_valid,
    input  logic [ADDRESSWIDTH-1:0] iss_rd,
    output logic                    iss_ready,
    input  logic [ADDRESSWIDTH-1:0] chk_ra1,
    input  logic [ADDRESSWIDTH-1:0] chk_ra2,
    output logic                    hazard,
    output logic                    we3,
    output logic [ADDRESSWIDTH-1:0] wa3,
    output logic [DATA_WIDTH-1:0]   wd3,
    output logic [REGNUM-1:0]       busy,
    output logic                    err_unexp
);

    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_MEM = 1'b1
    } last_t;

    last_t                   r_last;
    last_t                   w_last_nxt;
    logic                    w_alu_gnt;
    logic                    w_mem_gnt;
    logic                    w_iss_acc;
    logic                    r_we3;
    logic [ADDRESSWIDTH-1:0] r_wa3;
    logic [DATA_WIDTH-1:0]   r_wd3;
    logic [REGNUM-1:0]       r_busy;
    logic [REGNUM-1:0]       w_busy_nxt;
    logic                    r_err;

    // Grants are gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        w_alu_gnt  = 1'b0;
        w_mem_gnt  = 1'b0;
        w_last_nxt = r_last;
        if (rst_n) begin
            if (alu_valid && mem_valid) begin
                if (r_last == LAST_MEM) w_alu_gnt = 1'b1;
                else                    w_mem_gnt = 1'b1;
            end else if (alu_valid) begin
                w_alu_gnt = 1'b1;
            end else if (mem_valid) begin
                w_mem_gnt = 1'b1;
            end
        end
        if (w_alu_gnt)      w_last_nxt = LAST_ALU;
        else if (w_mem_gnt) w_last_nxt = LAST_MEM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_last <= LAST_MEM;
        else        r_last <= w_last_nxt;
    end

    // Write port: one cycle behind the grant, address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we3 <= 1'b0;
            r_wa3 <= '0;
            r_wd3 <= '0;
        end else begin
            r_we3 <= w_alu_gnt | w_mem_gnt;
            if (w_alu_gnt) begin
                r_wa3 <= alu_wa;
                r_wd3 <= alu_wd;
            end else if (w_mem_gnt) begin
                r_wa3 <= mem_wa;
                r_wd3 <= mem_wd;
            end
        end
    end

    assign w_iss_acc = iss_valid && !r_busy[iss_rd];

    // Clear first, then set, so a same-register set/clear leaves the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we3)     w_busy_nxt[r_wa3]  = 1'b0;
        if (w_iss_acc) w_busy_nxt[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (r_we3 && !r_busy[r_wa3]) r_err <= 1'b1;
        end
    end

    assign alu_ready = w_alu_gnt;
    assign mem_ready = w_mem_gnt;
    assign iss_ready = !r_busy[iss_rd];
    assign hazard    = r_busy[chk_ra1] | r_busy[chk_ra2];
    assign we3       = r_we3;
    assign wa3       = r_wa3;
    assign wd3       = r_wd3;
    assign busy      = r_busy;
    assign err_unexp = r_err;

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed bench for scalar_wb_arbiter: reset values, round-robin contention,
// single write with hazard tracking, WAW stall, unexpected write, set/clear
// collision and reset in the middle of a pending grant.

module tb_scalar_wb_arbiter;

    localparam int DW = 19;
    localparam int RN = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, mem_valid, iss_valid;
    logic [AW-1:0] alu_wa, mem_wa, iss_rd, chk_ra1, chk_ra2;
    logic [DW-1:0] alu_wd, mem_wd;
    logic          alu_ready, mem_ready, iss_ready, hazard, we3, err_unexp;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;
    logic [RN-1:0] busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    scalar_wb_arbiter #(.DATA_WIDTH(DW), .REGNUM(RN), .ADDRESSWIDTH(AW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_ready(mem_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .hazard(hazard),
        .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy), .err_unexp(err_unexp)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Contention tables: ALU wins first (pointer resets to MEM), then alternate.
    logic [AW-1:0] a_wa [2];
    logic [DW-1:0] a_wd [2];
    logic [AW-1:0] m_wa [2];
    logic [DW-1:0] m_wd [2];
    logic [AW-1:0] x_wa [4];
    logic [DW-1:0] x_wd [4];
    logic          x_alu [4];

    initial begin
        a_wa = '{4'd1, 4'd4};
        a_wd = '{19'h00A01, 19'h00A04};
        m_wa = '{4'd2, 4'd6};
        m_wd = '{19'h00B02, 19'h00B06};
        x_wa = '{4'd1, 4'd2, 4'd4, 4'd6};
        x_wd = '{19'h00A01, 19'h00B02, 19'h00A04, 19'h00B06};
        x_alu = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        alu_valid = 1'b1; alu_wa = 4'd1; alu_wd = 19'h1;
        mem_valid = 1'b1; mem_wa = 4'd2; mem_wd = 19'h2;
        iss_valid = 1'b0; iss_rd = '0; chk_ra1 = '0; chk_ra2 = '0;
        #2;
        check_eq("rst_alu_rdy", alu_ready, 0);
        check_eq("rst_mem_rdy", mem_ready, 0);
        check_eq("rst_we3", we3, 0);
        check_eq("rst_wa3", wa3, 0);
        check_eq("rst_wd3", wd3, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err_unexp, 0);
        tick();
        tick();
        check_eq("rst_we3_after_edges", we3, 0);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rst_n = 1'b1;

        // Reserve destinations 1,2,4,6 for the contention run.
        iss_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iss_rd = x_wa[i];
            #1;
            check_eq("iss_rdy_free", iss_ready, 1);
            tick();
        end
        iss_valid = 1'b0;
        check_eq("busy_reserved", busy, 32'h56);

        // Contention: ALU, MEM, ALU, MEM with back-to-back writes.
        begin
            int ai = 0;
            int mi = 0;
            for (int k = 0; k < 4; k++) begin
                alu_valid = (ai < 2);
                mem_valid = (mi < 2);
                if (ai < 2) begin alu_wa = a_wa[ai]; alu_wd = a_wd[ai]; end
                if (mi < 2) begin mem_wa = m_wa[mi]; mem_wd = m_wd[mi]; end
                #1;
                check_eq("ctn_alu_rdy", alu_ready, x_alu[k]);
                check_eq("ctn_mem_rdy", mem_ready, !x_alu[k]);
                if (k > 0) begin
                    check_eq("ctn_we3", we3, 1);
                    check_eq("ctn_wa3", wa3, x_wa[k-1]);
                    check_eq("ctn_wd3", wd3, x_wd[k-1]);
                end
                tick();
                if (x_alu[k]) ai++;
                else          mi++;
            end
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        check_eq("ctn_we3_last", we3, 1);
        check_eq("ctn_wa3_last", wa3, 6);
        check_eq("ctn_wd3_last", wd3, 32'h00B06);
        tick();
        check_eq("ctn_we3_idle", we3, 0);
        check_eq("ctn_busy_clear", busy, 0);
        check_eq("ctn_wa3_hold", wa3, 6);
        check_eq("ctn_err", err_unexp, 0);

        // Single ALU write to r3 with hazard tracking.
        iss_valid = 1'b1; iss_rd = 4'd3;
        #1;
        check_eq("s1_iss_rdy", iss_ready, 1);
        tick();
        iss_valid = 1'b0;
        chk_ra1 = 4'd3; chk_ra2 = 4'd0;
        #1;
        check_eq("s1_busy_set", busy, 32'h8);
        check_eq("s1_hazard_pend", hazard, 1);
        alu_valid = 1'b1; alu_wa = 4'd3; alu_wd = 19'h12345;
        #1;
        check_eq("s1_alu_rdy", alu_ready, 1);
        check_eq("s1_mem_rdy", mem_ready, 0);
        tick();
        alu_valid = 1'b0;
        #1;
        check_eq("s1_we3", we3, 1);
        check_eq("s1_wa3", wa3, 3);
        check_eq("s1_wd3", wd3, 32'h12345);
        check_eq("s1_busy_wcycle", busy, 32'h8);
        check_eq("s1_hazard_wcycle", hazard, 1);
        tick();
        check_eq("s1_we3_off", we3, 0);
        check_eq("s1_busy_clr", busy, 0);
        check_eq("s1_hazard_off", hazard, 0);
        check_eq("s1_wd3_hold", wd3, 32'h12345);

        // WAW stall on r5, hazard seen through the second source port.
        iss_valid = 1'b1; iss_rd = 4'd5;
        chk_ra1 = 4'd0; chk_ra2 = 4'd5;
        tick();
        check_eq("waw_iss_stall", iss_ready, 0);
        check_eq("waw_hazard_ra2", hazard, 1);
        alu_valid = 1'b1; alu_wa = 4'd5; alu_wd = 19'h55555;
        #1;
        check_eq("waw_alu_rdy", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        #1;
        check_eq("waw_we3", we3, 1);
        check_eq("waw_wa3", wa3, 5);
        check_eq("waw_iss_stall_wcycle", iss_ready, 0);
        tick();
        check_eq("waw_iss_free", iss_ready, 1);
        check_eq("waw_busy_clr", busy, 0);
        iss_valid = 1'b0;
        #1;
        check_eq("waw_hazard_off", hazard, 0);

        // Unexpected MEM write to r9.
        mem_valid = 1'b1; mem_wa = 4'd9; mem_wd = 19'h7FFFF;
        #1;
        check_eq("ux_mem_rdy", mem_ready, 1);
        check_eq("ux_err_before", err_unexp, 0);
        tick();
        mem_valid = 1'b0;
        check_eq("ux_we3", we3, 1);
        check_eq("ux_wa3", wa3, 9);
        check_eq("ux_wd3", wd3, 32'h7FFFF);
        tick();
        check_eq("ux_err_set", err_unexp, 1);
        check_eq("ux_we3_off", we3, 0);

        // Issue r7 in the same cycle a write to r7 lands: set wins.
        mem_valid = 1'b1; mem_wa = 4'd7; mem_wd = 19'h00777;
        tick();
        mem_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 4'd7;
        #1;
        check_eq("sc_we3", we3, 1);
        check_eq("sc_wa3", wa3, 7);
        check_eq("sc_iss_rdy", iss_ready, 1);
        tick();
        iss_valid = 1'b0;
        check_eq("sc_busy7", busy, 32'h80);
        tick();
        check_eq("sc_err_sticky", err_unexp, 1);

        // Leave the pointer at ALU, then reset while a MEM grant is offered.
        alu_valid = 1'b1; alu_wa = 4'd12; alu_wd = 19'h0C0C0;
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_wa = 4'd2; mem_wd = 19'h22222;
        #1;
        check_eq("rm_mem_rdy", mem_ready, 1);
        check_eq("rm_we3_prev", we3, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rm_mem_rdy_rst", mem_ready, 0);
        check_eq("rm_we3_rst", we3, 0);
        check_eq("rm_busy_rst", busy, 0);
        check_eq("rm_err_rst", err_unexp, 0);
        check_eq("rm_wa3_rst", wa3, 0);
        tick();
        check_eq("rm_no_pulse", we3, 0);
        rst_n = 1'b1;
        alu_valid = 1'b1; alu_wa = 4'd11; alu_wd = 19'h0BBBB;
        mem_valid = 1'b1; mem_wa = 4'd10; mem_wd = 19'h0AAAA;
        #1;
        check_eq("rm_tie_alu", alu_ready, 1);
        check_eq("rm_tie_mem", mem_ready, 0);
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        check_eq("rm_we3_post", we3, 1);
        check_eq("rm_wa3_post", wa3, 11);
        check_eq("rm_wd3_post", wd3, 32'h0BBBB);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
